// File: rtl/col_ctrl.sv
// col_ctrl: column controller for a small bit-cell column with four rows.
// Sequences one access at a time: IDLE (precharging, ready for a request),
// ACCESS (word line(s) active for ACC_CYC cycles), PRECH (PRE_CYC cycles of
// precharge) and back to IDLE. All array-control outputs are registered.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake; a request transfers on a rising
//                       edge where both are 1. req_ready is 1 only in IDLE
//                       and only while rst_n=1; requests seen in any other
//                       state are ignored, nothing is queued.
//   req_op              00 read true (WL), 01 write, 10 read complement (WLB),
//                       11 illegal (err pulse, no array activity)
//   req_addr            row select, decoded one-hot onto WL/WLB
//   req_wdata           write data, captured at acceptance
//   sa_out              sense-amplifier output, sampled at the end of a read
//   preb                precharge enable, active-low
//   w_en, write_bit     write driver enable and data
//   SAE                 sense-amplifier enable, last ACCESS cycle of a read
//   WL, WLB             true / complement word lines
//   rd_valid, rd_data   one-cycle read result
//   err                 one-cycle pulse on acceptance of op 11
//   fsm_state           current FSM state for observation
module col_ctrl #(
    parameter int unsigned PRE_CYC = 2,
    parameter int unsigned ACC_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [1:0] req_addr,
    input  logic       req_wdata,
    input  logic       sa_out,
    output logic       preb,
    output logic       w_en,
    output logic       write_bit,
    output logic       SAE,
    output logic [3:0] WL,
    output logic [3:0] WLB,
    output logic       rd_valid,
    output logic       rd_data,
    output logic       err,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        PRECH  = 2'd2
    } state_t;

    localparam logic [1:0] OP_RDT = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RDC = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYC - 1);
    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] op_q, op_n;
    logic [1:0] addr_q, addr_n;

    logic       preb_n, w_en_n, wbit_n, sae_n, rdv_n, rdd_n, err_n;
    logic [3:0] wl_n, wlb_n;

    // Word-line drive for the coming cycle, chosen from either the incoming
    // request (on acceptance) or the captured one (while in ACCESS).
    logic       drive;
    logic       last;
    logic [1:0] line_op;
    logic [1:0] line_addr;
    logic [3:0] line_oh;

    assign req_ready = rst_n && (state == IDLE);
    assign fsm_state = state;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_n      = op_q;
        addr_n    = addr_q;
        preb_n    = 1'b0;
        w_en_n    = 1'b0;
        sae_n     = 1'b0;
        wl_n      = 4'd0;
        wlb_n     = 4'd0;
        rdv_n     = 1'b0;
        err_n     = 1'b0;
        wbit_n    = write_bit;
        rdd_n     = rd_data;
        drive     = 1'b0;
        last      = 1'b0;
        line_op   = op_q;
        line_addr = addr_q;
        line_oh   = 4'd0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_ILL) begin
                        err_n = 1'b1;
                    end else begin
                        state_n   = ACCESS;
                        cnt_n     = ACC_LOAD;
                        op_n      = req_op;
                        addr_n    = req_addr;
                        line_op   = req_op;
                        line_addr = req_addr;
                        drive     = 1'b1;
                        // With a single ACCESS cycle the first cycle is also the last.
                        last      = (ACC_CYC == 1);
                        if (req_op == OP_WR) begin
                            wbit_n = req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    // This edge ends the last ACCESS cycle: sample the sense amp.
                    state_n = PRECH;
                    cnt_n   = PRE_LOAD;
                    if (op_q != OP_WR) begin
                        rdv_n = 1'b1;
                        rdd_n = (op_q == OP_RDC) ? ~sa_out : sa_out;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                    drive = 1'b1;
                    last  = (cnt == 4'd1);
                end
            end
            PRECH: begin
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (drive) begin
            line_oh = 4'b0001 << line_addr;
            preb_n  = 1'b1;
            case (line_op)
                OP_WR: begin
                    w_en_n = 1'b1;
                    wl_n   = line_oh;
                    wlb_n  = line_oh;
                end
                OP_RDT: begin
                    wl_n  = line_oh;
                    sae_n = last;
                end
                OP_RDC: begin
                    wlb_n = line_oh;
                    sae_n = last;
                end
                default: begin
                    preb_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_q      <= OP_RDT;
            addr_q    <= 2'd0;
            preb      <= 1'b0;
            w_en      <= 1'b0;
            write_bit <= 1'b0;
            SAE       <= 1'b0;
            WL        <= 4'd0;
            WLB       <= 4'd0;
            rd_valid  <= 1'b0;
            rd_data   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            addr_q    <= addr_n;
            preb      <= preb_n;
            w_en      <= w_en_n;
            write_bit <= wbit_n;
            SAE       <= sae_n;
            WL        <= wl_n;
            WLB       <= wlb_n;
            rd_valid  <= rdv_n;
            rd_data   <= rdd_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_col_ctrl.sv
// Bench for col_ctrl: instance 0 uses the default timing (ACC=2, PRE=2),
// instance 1 uses ACC=1, PRE=1. Inputs other than req_valid are shared;
// only one instance is driven at a time. Read results are pushed into a
// per-instance expected queue at acceptance and popped by a monitor when
// rd_valid is seen.
module tb_col_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] vld = 2'b00;
  logic [1:0] req_op = 2'b00;
  logic [1:0] req_addr = 2'b00;
  logic req_wdata = 1'b0;
  logic sa_out = 1'b0;

  logic [1:0] ready, preb, w_en, wbit, sae, rdv, rdd, err;
  logic [1:0][3:0] wl, wlb;
  logic [1:0][1:0] fst;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_acc[2];
  logic last_wbit[2];
  logic last_rd[2];
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  col_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(ready[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .sa_out(sa_out),
    .preb(preb[0]), .w_en(w_en[0]), .write_bit(wbit[0]), .SAE(sae[0]),
    .WL(wl[0]), .WLB(wlb[0]), .rd_valid(rdv[0]), .rd_data(rdd[0]), .err(err[0]),
    .fsm_state(fst[0])
  );

  col_ctrl #(.PRE_CYC(1), .ACC_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(ready[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .sa_out(sa_out),
    .preb(preb[1]), .w_en(w_en[1]), .write_bit(wbit[1]), .SAE(sae[1]),
    .WL(wl[1]), .WLB(wlb[1]), .rd_valid(rdv[1]), .rd_data(rdd[1]), .err(err[1]),
    .fsm_state(fst[1])
  );

  function automatic int acc_of(int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic int pre_of(int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops one expected {cycle, data} per rd_valid pulse and checks
  // that rd_data holds between pulses.
  task automatic monitor(int s);
    logic [16:0] e;
    int n;
    if (!rst_n) begin
      last_rd[s] = 1'b0;
    end else if (rdv[s]) begin
      n = (s == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) begin
        check($sformatf("u%0d_unexpected_rd_valid", s), 1, 0);
      end else begin
        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("u%0d_rd_cycle", s), cyc, int'(e[16:1]));
        check($sformatf("u%0d_rd_data", s), int'(rdd[s]), int'(e[0]));
        last_rd[s] = e[0];
      end
    end else begin
      check($sformatf("u%0d_rd_hold", s), int'(rdd[s]), int'(last_rd[s]));
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  task automatic check_zero(int s, string tag);
    check({tag, "_preb"}, int'(preb[s]), 0);
    check({tag, "_w_en"}, int'(w_en[s]), 0);
    check({tag, "_sae"}, int'(sae[s]), 0);
    check({tag, "_wl"}, int'(wl[s]), 0);
    check({tag, "_wlb"}, int'(wlb[s]), 0);
  endtask

  // Called and returns at a negedge. Drives one request on instance s and
  // checks every cycle of ACCESS and PRECH. With hold=1 req_valid stays high
  // and the acceptance spacing from the previous held request is checked.
  task automatic issue(int s, logic [1:0] op, logic [1:0] addr, logic wd, logic sa, bit hold);
    int acc, pre, a, n;
    logic [3:0] oh;
    string p;
    acc = acc_of(s);
    pre = pre_of(s);
    p = $sformatf("u%0d", s);
    oh = 4'b0001 << addr;
    vld[s] = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    sa_out = sa;
    n = 0;
    while (!ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready[s]) begin
      check({p, "_ready_timeout"}, 0, 1);
      vld[s] = 1'b0;
      return;
    end
    a = cyc;
    if (hold && last_acc[s] >= 0) check({p, "_spacing"}, a - last_acc[s], acc + pre + 1);
    last_acc[s] = a;
    if (op == 2'b00 || op == 2'b10) begin
      if (s == 0) exp_q0.push_back({16'(a + acc + 1), (op == 2'b10) ? ~sa : sa});
      else exp_q1.push_back({16'(a + acc + 1), (op == 2'b10) ? ~sa : sa});
    end
    if (op == 2'b01) last_wbit[s] = wd;
    @(negedge clk);
    if (!hold) vld[s] = 1'b0;
    if (op == 2'b11) begin
      check({p, "_err_pulse"}, int'(err[s]), 1);
      check({p, "_ill_ready"}, int'(ready[s]), 1);
      check_zero(s, {p, "_ill"});
      @(negedge clk);
      check({p, "_err_clear"}, int'(err[s]), 0);
      check({p, "_ill_ready2"}, int'(ready[s]), 1);
      return;
    end
    for (int k = 1; k <= acc; k++) begin
      check({p, "_acc_preb"}, int'(preb[s]), 1);
      check({p, "_acc_ready"}, int'(ready[s]), 0);
      check({p, "_acc_wl"}, int'(wl[s]), (op == 2'b10) ? 0 : int'(oh));
      check({p, "_acc_wlb"}, int'(wlb[s]), (op == 2'b00) ? 0 : int'(oh));
      check({p, "_acc_w_en"}, int'(w_en[s]), (op == 2'b01) ? 1 : 0);
      check({p, "_acc_sae"}, int'(sae[s]), (op != 2'b01 && k == acc) ? 1 : 0);
      check({p, "_write_bit"}, int'(wbit[s]), int'(last_wbit[s]));
      check({p, "_err_idle"}, int'(err[s]), 0);
      @(negedge clk);
    end
    for (int k = 1; k <= pre; k++) begin
      check_zero(s, {p, "_prech"});
      check({p, "_prech_ready"}, int'(ready[s]), 0);
      check({p, "_prech_wbit"}, int'(wbit[s]), int'(last_wbit[s]));
      @(negedge clk);
    end
    check({p, "_ready_back"}, int'(ready[s]), 1);
    check_zero(s, {p, "_idle"});
  endtask

  initial begin
    last_acc[0] = -1;
    last_acc[1] = -1;
    last_wbit[0] = 1'b0;
    last_wbit[1] = 1'b0;
    last_rd[0] = 1'b0;
    last_rd[1] = 1'b0;

    // Reset: outputs at reset values, req_ready low while rst_n=0.
    rst_n = 1'b0;
    vld = 2'b11;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("u%0d_rst_ready", s), int'(ready[s]), 0);
      check_zero(s, $sformatf("u%0d_rst", s));
      check($sformatf("u%0d_rst_wbit", s), int'(wbit[s]), 0);
      check($sformatf("u%0d_rst_rdv", s), int'(rdv[s]), 0);
      check($sformatf("u%0d_rst_rdd", s), int'(rdd[s]), 0);
      check($sformatf("u%0d_rst_err", s), int'(err[s]), 0);
    end
    vld = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    // Default timing: write then read, complement read, more data values.
    issue(0, 2'b01, 2'd0, 1'b0, 1'b0, 0);
    issue(0, 2'b00, 2'd0, 1'b0, 1'b0, 0);
    issue(0, 2'b10, 2'd1, 1'b0, 1'b1, 0);
    issue(0, 2'b01, 2'd2, 1'b1, 1'b0, 0);
    issue(0, 2'b00, 2'd2, 1'b0, 1'b1, 0);
    issue(0, 2'b10, 2'd3, 1'b0, 1'b0, 0);
    issue(0, 2'b11, 2'd1, 1'b1, 1'b1, 0);

    // Back-to-back with req_valid held high.
    last_acc[0] = -1;
    issue(0, 2'b00, 2'd1, 1'b0, 1'b1, 1);
    issue(0, 2'b01, 2'd3, 1'b0, 1'b0, 1);
    issue(0, 2'b10, 2'd0, 1'b0, 1'b0, 1);
    vld[0] = 1'b0;
    @(negedge clk);

    // Reset in the first ACCESS cycle of a read: aborted, no rd_valid.
    vld[0] = 1'b1;
    req_op = 2'b00;
    req_addr = 2'd3;
    sa_out = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    check("u0_midrd_wl", int'(wl[0]), 8);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero(0, "u0_midrst");
    check("u0_midrst_ready", int'(ready[0]), 0);
    check("u0_midrst_rdv", int'(rdv[0]), 0);
    check("u0_midrst_wbit", int'(wbit[0]), 0);
    last_wbit[0] = 1'b0;
    last_wbit[1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("u0_postrst_ready", int'(ready[0]), 1);
    check("u0_postrst_rdv", int'(rdv[0]), 0);
    @(negedge clk);

    // Single-cycle timing instance.
    issue(1, 2'b00, 2'd2, 1'b0, 1'b1, 0);
    issue(1, 2'b10, 2'd1, 1'b0, 1'b1, 0);
    issue(1, 2'b01, 2'd3, 1'b1, 1'b0, 0);
    issue(1, 2'b11, 2'd0, 1'b0, 1'b0, 0);
    last_acc[1] = -1;
    issue(1, 2'b00, 2'd0, 1'b0, 1'b0, 1);
    issue(1, 2'b10, 2'd2, 1'b0, 1'b0, 1);
    issue(1, 2'b00, 2'd3, 1'b0, 1'b1, 1);
    vld[1] = 1'b0;
    @(negedge clk);

    // Random mix on both instances.
    for (int i = 0; i < 16; i++) begin
      issue(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (4) @(negedge clk);
    check("u0_exp_q_empty", exp_q0.size(), 0);
    check("u1_exp_q_empty", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
